// File: rtl/awb_gain_estimator_pkg.sv
// Shared constants and FSM state type for the gray-world AWB gain estimator.
// Gains are unsigned 4-bit values in units of 1/8.
package awb_pkg;
    localparam int GAIN_W    = 4;
    localparam int GAIN_FRAC = 3;
    localparam logic [GAIN_W-1:0] GAIN_MAX = 4'd15;
    localparam logic [GAIN_W-1:0] GAIN_MIN = 4'd1;

    localparam int PIX_W = 10;
    localparam int B_LSB = 0;
    localparam int G_LSB = 10;
    localparam int R_LSB = 20;

    typedef enum logic [1:0] {IDLE, DIV_R, DIV_B, DONE} awb_state_e;
endpackage

// File: rtl/awb_gain_estimator_if.sv
// Two-pixel-per-clock RGB stream tapped by the AWB statistics engine.
interface awb_gain_estimator_if;
    logic        input_hsync;
    logic        input_vsync;
    logic        input_den;
    logic [29:0] input_data_even;
    logic [29:0] input_data_odd;

    modport master (output input_hsync, input_vsync, input_den, input_data_even, input_data_odd);
    modport slave  (input  input_hsync, input_vsync, input_den, input_data_even, input_data_odd);
endinterface

// File: rtl/awb_gain_estimator_div4.sv
// 4-step restoring divider producing a 4-bit quotient; requires num_i < 16*den_i.
// quot_o/done_o present the final quotient during the last iteration cycle.
module awb_div4 #(
    parameter int NUM_W = 35,
    parameter int DEN_W = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start_i,
    input  logic [NUM_W-1:0] num_i,
    input  logic [DEN_W-1:0] den_i,
    output logic [3:0]       quot_o,
    output logic             done_o
);
    localparam int W = DEN_W + 4;

    logic [NUM_W-1:0] rem_q, rem_d;
    logic [DEN_W-1:0] den_q;
    logic [3:0]       quot_q, quot_d;
    logic [1:0]       step_q;
    logic             busy_q;

    logic [1:0]       shamt;
    logic [W-1:0]     den_sh;
    logic [W-1:0]     rem_ext;
    logic             take;

    always_comb begin
        shamt   = ~step_q;
        den_sh  = W'(den_q) << shamt;
        rem_ext = W'(rem_q);
        take    = busy_q && (rem_ext >= den_sh);
        quot_d  = quot_q;
        rem_d   = rem_q;
        if (take) begin
            quot_d[shamt] = 1'b1;
            rem_d         = NUM_W'(rem_ext - den_sh);
        end
    end

    assign quot_o = quot_d;
    assign done_o = busy_q && (step_q == 2'd3);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rem_q  <= '0;
            den_q  <= '0;
            quot_q <= '0;
            step_q <= '0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            rem_q  <= num_i;
            den_q  <= den_i;
            quot_q <= '0;
            step_q <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            rem_q  <= rem_d;
            quot_q <= quot_d;
            step_q <= step_q + 2'd1;
            busy_q <= (step_q != 2'd3);
        end
    end
endmodule

// File: rtl/awb_gain_estimator.sv
// Gray-world AWB statistics: per-frame saturating RGB sums, red/blue gains = 7*G/X at each vsync.
// Optional build macro AWB_SAT_EXCLUDE_EN drops pixels with any channel >= SAT_THRESH from the sums.
module awb_gain_estimator
    import awb_pkg::*;
#(
    parameter int ACC_W      = 32,
    parameter int GREEN_GAIN = 7,
    parameter int INIT_RED   = 10,
    parameter int INIT_BLUE  = 9,
    parameter int SAT_THRESH = 1020
) (
    input  logic              clock,
    input  logic              reset_n,
    awb_gain_estimator_if.slave pix,
    output logic [GAIN_W-1:0] red_gain,
    output logic [GAIN_W-1:0] green_gain,
    output logic [GAIN_W-1:0] blue_gain,
    output logic              gain_valid,
    output logic              overrun
);
    localparam int N_W = ACC_W + GAIN_FRAC;

    function automatic logic [PIX_W-1:0] chan(input logic [3*PIX_W-1:0] px, input int lsb);
        return px[lsb +: PIX_W];
    endfunction

    function automatic logic [PIX_W-1:0] pick(input logic ok, input logic [3*PIX_W-1:0] px, input int lsb);
        return ok ? chan(px, lsb) : '0;
    endfunction

    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                                 input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
        logic [ACC_W:0] s;
        s = {1'b0, acc} + (ACC_W+1)'(a) + (ACC_W+1)'(b);
        return s[ACC_W] ? '1 : s[ACC_W-1:0];
    endfunction

    // Gain saturates at 15 when X is empty or 7*G/X would not fit in 4 bits.
    function automatic logic bypass(input logic [ACC_W-1:0] den, input logic [N_W-1:0] n);
        return (den == '0) || ({1'b0, n} >= {den, {GAIN_W{1'b0}}});
    endfunction

    function automatic logic [GAIN_W-1:0] gain_fix(input logic byp, input logic [GAIN_W-1:0] q);
        if (byp) return GAIN_MAX;
        return (q < GAIN_MIN) ? GAIN_MIN : q;
    endfunction

    logic ok_e, ok_o;
`ifdef AWB_SAT_EXCLUDE_EN
    function automatic logic pix_ok(input logic [3*PIX_W-1:0] px);
        return (chan(px, R_LSB) < PIX_W'(SAT_THRESH)) && (chan(px, G_LSB) < PIX_W'(SAT_THRESH))
            && (chan(px, B_LSB) < PIX_W'(SAT_THRESH));
    endfunction
    assign ok_e = pix_ok(pix.input_data_even);
    assign ok_o = pix_ok(pix.input_data_odd);
`else
    logic [PIX_W-1:0] unused_sat_thresh;
    assign unused_sat_thresh = PIX_W'(SAT_THRESH);
    assign ok_e = 1'b1;
    assign ok_o = 1'b1;
`endif

    logic unused_hsync;
    assign unused_hsync = pix.input_hsync;

    logic                vsync_q, vs_edge;
    logic                frame_seen_q, frame_seen_d;
    awb_state_e          state_q, state_d;
    logic                started_q, started_d;
    logic [ACC_W-1:0]    sum_r_q, sum_r_d, sum_g_q, sum_g_d, sum_b_q, sum_b_d;
    logic [ACC_W-1:0]    calc_r_q, calc_r_d, calc_b_q, calc_b_d;
    logic [N_W-1:0]      n_q, n_d;
    logic [GAIN_W-1:0]   red_res_q, red_res_d;
    logic [GAIN_W-1:0]   red_gain_q, red_gain_d, blue_gain_q, blue_gain_d;
    logic                gain_valid_q, gain_valid_d;
    logic                overrun_q, overrun_d;

    logic                div_start, div_done;
    logic [ACC_W-1:0]    div_den;
    logic [3:0]          div_quot;

    assign vs_edge = pix.input_vsync & ~vsync_q;

    // The edge cycle clears the sums but its own pixels open the new frame.
    always_comb begin
        sum_r_d = vs_edge ? '0 : sum_r_q;
        sum_g_d = vs_edge ? '0 : sum_g_q;
        sum_b_d = vs_edge ? '0 : sum_b_q;
        if (pix.input_den) begin
            sum_r_d = sat_add(sum_r_d, pick(ok_e, pix.input_data_even, R_LSB), pick(ok_o, pix.input_data_odd, R_LSB));
            sum_g_d = sat_add(sum_g_d, pick(ok_e, pix.input_data_even, G_LSB), pick(ok_o, pix.input_data_odd, G_LSB));
            sum_b_d = sat_add(sum_b_d, pick(ok_e, pix.input_data_even, B_LSB), pick(ok_o, pix.input_data_odd, B_LSB));
        end
    end

    always_comb begin
        frame_seen_d = frame_seen_q;
        state_d      = state_q;
        started_d    = started_q;
        calc_r_d     = calc_r_q;
        calc_b_d     = calc_b_q;
        n_d          = n_q;
        red_res_d    = red_res_q;
        red_gain_d   = red_gain_q;
        blue_gain_d  = blue_gain_q;
        gain_valid_d = 1'b0;
        overrun_d    = overrun_q;
        div_start    = 1'b0;
        div_den      = (state_q == DIV_B) ? calc_b_q : calc_r_q;

        if (vs_edge) begin
            if (!frame_seen_q) begin
                frame_seen_d = 1'b1;
            end else if (state_q == IDLE) begin
                calc_r_d  = sum_r_q;
                calc_b_d  = sum_b_q;
                n_d       = N_W'(sum_g_q) * N_W'(GREEN_GAIN);
                state_d   = DIV_R;
                started_d = 1'b0;
            end else begin
                overrun_d = 1'b1;
            end
        end

        case (state_q)
            DIV_R: begin
                div_start = !started_q;
                started_d = 1'b1;
                if (div_done) begin
                    red_res_d = gain_fix(bypass(calc_r_q, n_q), div_quot);
                    state_d   = DIV_B;
                    started_d = 1'b0;
                end
            end
            DIV_B: begin
                div_start = !started_q;
                started_d = 1'b1;
                if (div_done) begin
                    red_gain_d   = red_res_q;
                    blue_gain_d  = gain_fix(bypass(calc_b_q, n_q), div_quot);
                    gain_valid_d = 1'b1;
                    state_d      = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: ;
        endcase
    end

    awb_div4 #(.NUM_W(N_W), .DEN_W(ACC_W)) u_div (
        .clock   (clock),
        .reset_n (reset_n),
        .start_i (div_start),
        .num_i   (n_q),
        .den_i   (div_den),
        .quot_o  (div_quot),
        .done_o  (div_done)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vsync_q      <= 1'b0;
            frame_seen_q <= 1'b0;
            state_q      <= IDLE;
            started_q    <= 1'b0;
            sum_r_q      <= '0;
            sum_g_q      <= '0;
            sum_b_q      <= '0;
            calc_r_q     <= '0;
            calc_b_q     <= '0;
            n_q          <= '0;
            red_res_q    <= '0;
            red_gain_q   <= GAIN_W'(INIT_RED);
            blue_gain_q  <= GAIN_W'(INIT_BLUE);
            gain_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            vsync_q      <= pix.input_vsync;
            frame_seen_q <= frame_seen_d;
            state_q      <= state_d;
            started_q    <= started_d;
            sum_r_q      <= sum_r_d;
            sum_g_q      <= sum_g_d;
            sum_b_q      <= sum_b_d;
            calc_r_q     <= calc_r_d;
            calc_b_q     <= calc_b_d;
            n_q          <= n_d;
            red_res_q    <= red_res_d;
            red_gain_q   <= red_gain_d;
            blue_gain_q  <= blue_gain_d;
            gain_valid_q <= gain_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign red_gain   = red_gain_q;
    assign green_gain = GAIN_W'(GREEN_GAIN);
    assign blue_gain  = blue_gain_q;
    assign gain_valid = gain_valid_q;
    assign overrun    = overrun_q;
endmodule

// File: tb/tb_awb_gain_estimator.sv
// Directed bench for awb_gain_estimator: frames of constant pixels, vsync edges, overrun and mid-compute reset.
module tb_awb_gain_estimator;
    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    awb_gain_estimator_if pix_if();
    logic [3:0] red_gain, green_gain, blue_gain;
    logic       gain_valid, overrun;

    awb_gain_estimator dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .pix        (pix_if),
        .red_gain   (red_gain),
        .green_gain (green_gain),
        .blue_gain  (blue_gain),
        .gain_valid (gain_valid),
        .overrun    (overrun)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [29:0] px(input int r, input int g, input int b);
        return {10'(r), 10'(g), 10'(b)};
    endfunction

    task automatic frame(input logic [29:0] pe, input logic [29:0] po, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
            pix_if.input_den       = 1'b1;
            pix_if.input_data_even = pe;
            pix_if.input_data_odd  = po;
            pix_if.input_hsync     = (i % 10 == 0);
        end
        @(posedge clock); #1;
        pix_if.input_den   = 1'b0;
        pix_if.input_hsync = 1'b0;
    endtask

    // Raises vsync (cycle E = offset 0) and watches 24 cycles; optional second edge / reset at given offsets.
    task automatic run_edge(input int second_at, input int rst_at,
                            output int npulse, output int pcyc, output logic [3:0] pr, output logic [3:0] pb);
        npulse = 0; pcyc = -1; pr = 'x; pb = 'x;
        pix_if.input_vsync = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(posedge clock); #1;
            if (k == 1) pix_if.input_vsync = 1'b0;
            if (second_at > 0 && k == second_at) pix_if.input_vsync = 1'b1;
            if (second_at > 0 && k == second_at + 1) pix_if.input_vsync = 1'b0;
            if (k == rst_at) begin
                reset_n = 1'b0;
                #1;
                chk("midrst_red", red_gain, 10);
                chk("midrst_green", green_gain, 7);
                chk("midrst_blue", blue_gain, 9);
                chk("midrst_gv", gain_valid, 0);
                chk("midrst_ovr", overrun, 0);
                reset_n = 1'b1;
            end
            if (gain_valid === 1'b1) begin
                npulse++;
                if (pcyc < 0) begin
                    pcyc = k; pr = red_gain; pb = blue_gain;
                end
            end
        end
    endtask

    int np, pc;
    logic [3:0] pr, pb;

    initial begin
        reset_n = 1'b0;
        pix_if.input_hsync = 1'b0;
        pix_if.input_vsync = 1'b0;
        pix_if.input_den   = 1'b0;
        pix_if.input_data_even = '0;
        pix_if.input_data_odd  = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_red", red_gain, 10);
        chk("rst_green", green_gain, 7);
        chk("rst_blue", blue_gain, 9);
        chk("rst_gv", gain_valid, 0);
        chk("rst_ovr", overrun, 0);
        reset_n = 1'b1;

        // First frame after reset is discarded
        frame(px(512, 512, 512), px(512, 512, 512), 100);
        run_edge(0, 0, np, pc, pr, pb);
        chk("first_npulse", np, 0);

        frame(px(512, 512, 512), px(512, 512, 512), 100);
        run_edge(0, 0, np, pc, pr, pb);
        chk("gray_npulse", np, 1);
        chk("gray_lat", pc, 11);
        chk("gray_red", pr, 7);
        chk("gray_blue", pb, 7);
        chk("gray_green", green_gain, 7);

        frame(px(256, 512, 1023), px(256, 512, 1023), 100);
        run_edge(0, 0, np, pc, pr, pb);
        chk("tint_npulse", np, 1);
        chk("tint_lat", pc, 11);
        chk("tint_red", pr, 14);
        chk("tint_blue", pb, 3);

        frame(px(0, 512, 512), px(0, 512, 512), 100);
        run_edge(0, 0, np, pc, pr, pb);
        chk("r0_red", pr, 15);
        chk("r0_blue", pb, 7);

        frame(px(512, 0, 512), px(512, 0, 512), 100);
        run_edge(0, 0, np, pc, pr, pb);
        chk("g0_red", pr, 1);
        chk("g0_blue", pb, 1);
        chk("g0_ovr", overrun, 0);

        frame(px(512, 512, 512), px(512, 512, 512), 100);
        run_edge(4, 0, np, pc, pr, pb);
        chk("ovr_npulse", np, 1);
        chk("ovr_lat", pc, 11);
        chk("ovr_red", pr, 7);
        chk("ovr_blue", pb, 7);
        chk("ovr_flag", overrun, 1);

        frame(px(1023, 1023, 1023), px(256, 512, 512), 100);
        run_edge(0, 0, np, pc, pr, pb);
`ifdef AWB_SAT_EXCLUDE_EN
        chk("mix_red", pr, 14);
`else
        chk("mix_red", pr, 8);
`endif
        chk("mix_blue", pb, 7);
        chk("ovr_sticky", overrun, 1);

        frame(px(512, 512, 512), px(512, 512, 512), 100);
        run_edge(0, 5, np, pc, pr, pb);
        chk("midrst_npulse", np, 0);
        chk("midrst_red_after", red_gain, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
